// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver and transmitter): state encoding, data width, default bit timing.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 104;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level (1).
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_reg <= 2'b11;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    logic                 rxs;
    uart_state_t          state_reg, state_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 armed_reg, armed_next;
    logic [1:0]           fill_reg;
    logic                 deliver;
    logic                 frame_bad;
    logic [DATA_BITS-1:0] rx_byte_reg;
    logic                 rx_valid_reg;
    logic                 overrun_reg;
    logic                 frame_err_reg;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_reg, parity_bad_next;
    logic                 parity_err_reg;
`endif

    sync2 u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rxs)
    );

    // The synchronizer resets to 1, so arming waits until both flops hold real line samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_reg <= 2'b00;
        end else begin
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            armed_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            armed_reg   <= armed_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg + TW'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        armed_next   = armed_reg | (rxs & fill_reg[1]);
        deliver      = 1'b0;
        frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (armed_reg && !rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next   = '0;
                    shift_next   = {rxs, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (timer_reg == BIT_LAST) begin
                    timer_next      = '0;
                    parity_bad_next = rxs ^ even_parity(shift_reg);
                    state_next      = STOP;
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                // Leave at mid-stop so a start bit with no idle gap is still caught.
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                    if (rxs) begin
                        deliver = 1'b1;
                    end else begin
                        frame_bad  = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_byte_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            if (rx_ack) begin
                rx_valid_reg <= 1'b0;
                overrun_reg  <= 1'b0;
            end
            if (deliver) begin
                if (rx_valid_reg && !rx_ack) begin
                    overrun_reg <= 1'b1;
                end else begin
                    rx_byte_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_err_reg <= 1'b0;
        end else begin
            if (rx_ack) begin
                parity_err_reg <= 1'b0;
            end
            if (deliver && !(rx_valid_reg && !rx_ack)) begin
                parity_err_reg <= parity_bad_reg;
            end
        end
    end
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_byte   = rx_byte_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_busy   = (state_reg != IDLE);
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uartrx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per serial bit; legal values are 4 and above.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  in  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_ack  in  1  consumer acknowledge; clears rx_valid, overrun and parity_err.
REQ-006 SHALL have port rx_byte  out  8  last accepted data byte.
REQ-007 SHALL have port rx_valid  out  1  rx_byte holds an unacknowledged byte.
REQ-008 SHALL have port rx_busy  out  1  frame reception in progress (state not IDLE).
REQ-009 SHALL have port frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  out  1  sticky: a complete byte was dropped because rx_valid was still set.
REQ-011 SHALL have port parity_err  out  1  parity mismatch on the byte currently in rx_byte.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, and use one bit-timer and one 3-bit bit index.
REQ-014 IDLE: SHALL move to START, timer=0, when rxs is 0 and the receiver is armed.
REQ-015 SHALL arm only after rxs has been sampled 1 at least once since reset; a line held low out of reset starts no frame.
REQ-016 START: at timer = CLKS_PER_BIT/2-1 SHALL sample rxs; 1 -> IDLE (glitch, no flags), 0 -> DATA with timer and index cleared.
REQ-017 DATA: SHALL sample every CLKS_PER_BIT cycles (mid-bit), shifting bits LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-018 STOP: at the mid-bit sample, rxs=1 SHALL deliver the byte; rxs=0 SHALL pulse frame_err for 1 cycle, discard the byte, and return to IDLE disarmed.
REQ-019 SHALL return to IDLE directly after the stop-bit sample so back-to-back frames with no idle gap are received.
REQ-020 Delivery SHALL load rx_byte and set rx_valid on the cycle after the stop sample; rx_valid holds until rx_ack is sampled high.
REQ-021 Delivery while rx_valid=1 and rx_ack=0 SHALL keep the old rx_byte, drop the new byte, and set overrun.
REQ-022 Delivery in the same cycle as rx_ack SHALL load the new byte, keep rx_valid=1, and leave overrun clear.
REQ-023 rx_ack while rx_valid=0 SHALL have no effect other than clearing overrun.
REQ-024 Total latency SHALL be at most 2 sync cycles + 9.5 bit times (10.5 with parity) + 1 cycle, measured from the start-bit falling edge to rx_valid.

Reset
REQ-025 Asserting rstn low SHALL force rx_byte=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0, state=IDLE, disarmed, and synchronizer flops=1, all immediately.
REQ-026 Reset mid-frame SHALL abort the frame with no partial delivery; after release, reception resumes only after rxs=1 is seen.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, SHALL expect one even-parity bit after bit 7; a mismatch still delivers the byte and sets parity_err alongside it, and parity_err clears on rx_ack.
REQ-028 Without UART_RX_PARITY_EN, frame format SHALL be 8N1, the PARITY state is unreachable, and parity_err is constant 0.

Structure
REQ-029 SHALL place the state encoding typedef, DATA_BITS=8, and the default CLKS_PER_BIT in shared package uart_pkg, shared with the transmitter.
REQ-030 SHALL instantiate one sub-module, sync2, for the reset-to-1 two-flop synchronizer; everything else stays in uartrx.

Verification (CLKS_PER_BIT=16)
REQ-031 Drive 8N1 frame 0xA5, no ack -> rx_byte=0xA5 and rx_valid=1 within 2+152+1 cycles of the start edge; rx_valid stays 1 until rx_ack.
REQ-032 Drive a 5-cycle low glitch on idle rx -> no rx_valid, no frame_err, and rx_busy returns to 0 by cycle 10.
REQ-033 Drive 0x3C with stop bit low -> frame_err is a 1-cycle pulse and rx_valid stays 0; the next valid frame 0x11, sent after the line returns high, is received.
REQ-034 Drive 0x01 then 0x02 back-to-back without ack -> rx_byte=0x01 and overrun=1; rx_ack clears both rx_valid and overrun.
REQ-035 Assert rstn low during bit 4 of 0xFF, hold rx low 3 bit times, then high -> all outputs 0 and no frame until rx goes high; the next frame 0x55 is received correctly.
REQ-036 With UART_RX_PARITY_EN, drive 0x07 with parity bit 0 -> rx_byte=0x07, rx_valid=1, parity_err=1; rx_ack clears parity_err.
